// File: rtl/stall_sink_pkg.sv
// Shared types and helpers for the stall_sink_buf receive buffer.
package stall_sink_pkg;

  localparam int DEF_W     = 32;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_LAT   = 10;

  // One extra MSB on pointers and level distinguishes full from empty.
  typedef logic [$clog2(DEF_DEPTH):0] ptr_t;
  typedef logic [$clog2(DEF_DEPTH):0] level_t;

  // Occupancy at which upstream must be told to stop.
  function automatic int thresh(input int depth, input int lat);
    return depth - lat;
  endfunction

endpackage

// File: rtl/stall_sink_buf_if.sv
// Beat handshake bundle: upstream beats in, stall back, head beats out.
interface stall_sink_buf_if #(
  parameter int W = stall_sink_pkg::DEF_W
);
  logic [W-1:0] in;
  logic         in_vld;
  logic         stall_r;
  logic [W-1:0] out;
  logic         out_vld;
  logic         out_accept;

  modport master (output in, in_vld, out_accept, input stall_r, out, out_vld);
  modport slave  (input in, in_vld, out_accept, output stall_r, out, out_vld);
endinterface

// File: rtl/stall_sink_fifo.sv
// Flop-array FIFO with wrap-bit pointers; reports full, empty and occupancy.
module stall_sink_fifo
  import stall_sink_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output level_t       level
);

  localparam int AW = $clog2(DEPTH);

  if ($bits(ptr_t) != AW + 1) begin : g_bad_width
    $error("stall_sink_fifo: DEPTH does not match stall_sink_pkg::DEF_DEPTH");
  end

  logic [W-1:0] mem [DEPTH];
  ptr_t         wr_ptr;
  ptr_t         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  // NOTE: storage is not reset; pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = level_t'(wr_ptr - rd_ptr);

endmodule

// File: rtl/stall_sink_buf.sv
// Never-drop receive buffer with early registered stall and sticky overflow flag.
// Optional 0-cycle empty-FIFO bypass when STALL_SINK_BYPASS_EN is defined.
module stall_sink_buf
  import stall_sink_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LAT   = DEF_LAT
) (
  input  logic           clk,
  input  logic           rst_n,
  stall_sink_buf_if.slave bus,
  output logic           ovf_r,
  output level_t         level_r
);

  localparam int THRESH = thresh(DEPTH, LAT);

  if (LAT >= DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("stall_sink_buf: need LAT < DEPTH and DEPTH a power of two");
  end

  logic         fifo_full;
  logic         fifo_empty;
  logic [W-1:0] fifo_rdata;
  logic         push;
  logic         pop;
  logic         stall_q;
  level_t       level_w;

`ifdef STALL_SINK_BYPASS_EN
  logic bypass;

  // A beat arriving at an empty FIFO is shown immediately and only stored if not taken.
  assign bypass      = fifo_empty & bus.in_vld;
  assign push        = bus.in_vld & ~fifo_full & ~(bypass & bus.out_accept);
  assign bus.out     = bypass ? bus.in : fifo_rdata;
  assign bus.out_vld = ~fifo_empty | bus.in_vld;
`else
  assign push        = bus.in_vld & ~fifo_full;
  assign bus.out     = fifo_rdata;
  assign bus.out_vld = ~fifo_empty;
`endif

  assign pop     = ~fifo_empty & bus.out_accept;
  assign level_w = level_r + level_t'(push) - level_t'(pop);

  stall_sink_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (bus.in),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_r)
  );

  // Stall is judged on next-cycle occupancy so LAT trailing beats still fit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      stall_q <= (level_w >= level_t'(THRESH));
      ovf_r   <= ovf_r | (bus.in_vld & fifo_full);
    end
  end

  assign bus.stall_r = stall_q;

endmodule

// File: tb/tb_stall_sink_buf.sv
// Self-checking bench for stall_sink_buf: vector table, directed corners, random vs queue model.
module tb_stall_sink_buf;
  import stall_sink_pkg::*;

  localparam int W      = 32;
  localparam int DEPTH  = 16;
  localparam int LAT    = 10;
  localparam int THRESH = 6;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   ovf_r;
  level_t level_r;

  stall_sink_buf_if #(.W(W)) bus ();

  stall_sink_buf #(.W(W), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .ovf_r   (ovf_r),
    .level_r (level_r)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the buffer contents as a queue plus the sticky error flag.
  logic [W-1:0] mq[$];
  bit           m_ovf;

  function automatic bit byp_en();
`ifdef STALL_SINK_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_vld();
    return (mq.size() > 0) || (byp_en() && bus.in_vld);
  endfunction

  function automatic logic [W-1:0] exp_out();
    return (mq.size() > 0) ? mq[0] : bus.in;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
  endtask

  task automatic drive(input logic vld, input logic [W-1:0] data, input logic acc);
    @(negedge clk);
    bus.in_vld     = vld;
    bus.in         = data;
    bus.out_accept = acc;
    #1;
  endtask

  task automatic model_check(input string tag);
    check({tag, ".out_vld"}, bus.out_vld, exp_vld());
    if (exp_vld()) check({tag, ".out"}, bus.out, exp_out());
    check({tag, ".level"}, level_r, mq.size());
    check({tag, ".stall"}, bus.stall_r, mq.size() >= THRESH);
    check({tag, ".ovf"}, ovf_r, m_ovf);
  endtask

  // Advance one edge and apply the buffer rules to the model.
  task automatic tick();
    int           pre;
    bit           vld_now;
    bit           acc;
    logic [W-1:0] d;
    pre     = mq.size();
    vld_now = bus.in_vld;
    acc     = bus.out_accept;
    d       = bus.in;
    @(posedge clk);
    if (acc && pre > 0) void'(mq.pop_front());
    if (vld_now) begin
      if (pre == DEPTH) m_ovf = 1'b1;
      else if (!(byp_en() && pre == 0 && acc)) mq.push_back(d);
    end
  endtask

  task automatic cycle(input string tag, input logic vld, input logic [W-1:0] data,
                       input logic acc, output logic [W-1:0] got, output bit took);
    drive(vld, data, acc);
    model_check(tag);
    got  = bus.out;
    took = bus.out_vld & acc;
    tick();
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.in_vld     = 1'b0;
    bus.in         = '0;
    bus.out_accept = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic         vld;
    logic [W-1:0] data;
    logic         acc;
    logic         exp_vld;
    logic [W-1:0] exp_out;
    int           exp_level;
    logic         exp_stall;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [W-1:0] got;
    bit           took;
    logic [W-1:0] seen[$];
    logic         ev;
    logic [W-1:0] eo;

    // Fill: 16 beats with no draining, then one beat into a full buffer, then observe.
    for (int i = 0; i < 16; i++)
      vecs[i] = '{1'b1, 32'h1000_0000 + i, 1'b0, (i > 0), 32'h1000_0000, i, (i >= THRESH), 1'b0};
    vecs[16] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h1000_0000, 16, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h1000_0000, 16, 1'b1, 1'b1};

    // Reset state
    rst_n = 1'b0;
    bus.in_vld = 1'b0; bus.in = '0; bus.out_accept = 1'b0;
    #2;
    check("rst.out_vld", bus.out_vld, 1'b0);
    check("rst.stall", bus.stall_r, 1'b0);
    check("rst.level", level_r, 0);
    check("rst.ovf", ovf_r, 1'b0);
    do_reset();

    // Pass-through with downstream always accepting
    for (int k = 1; k <= 5; k++) begin
      cycle("pass", 1'b1, 32'hA5A5_0000 + k, 1'b1, got, took);
      if (took) seen.push_back(got);
    end
    for (int k = 0; k < 2; k++) begin
      cycle("pass_idle", 1'b0, '0, 1'b1, got, took);
      if (took) seen.push_back(got);
    end
    check("pass.count", seen.size(), 5);
    for (int k = 0; k < 5 && k < seen.size(); k++)
      check("pass.data", seen[k], 32'hA5A5_0001 + k);

    // Threshold and overflow vectors
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].vld, vecs[i].data, vecs[i].acc);
      ev = vecs[i].exp_vld;
      eo = vecs[i].exp_out;
      if (byp_en() && vecs[i].exp_level == 0 && vecs[i].vld) begin
        ev = 1'b1;
        eo = vecs[i].data;
      end
      check("vec.out_vld", bus.out_vld, ev);
      if (ev) check("vec.out", bus.out, eo);
      check("vec.level", level_r, vecs[i].exp_level);
      check("vec.stall", bus.stall_r, vecs[i].exp_stall);
      check("vec.ovf", ovf_r, vecs[i].exp_ovf);
      tick();
    end

    // Release: drain the 16 stored beats; stall follows occupancy with no hysteresis
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, '0, 1'b1);
      check("rel.data", bus.out, 32'h1000_0000 + k);
      check("rel.stall", bus.stall_r, (16 - k) >= THRESH);
      model_check("rel");
      tick();
    end
    drive(1'b0, '0, 1'b0);
    check("rel.empty", bus.out_vld, 1'b0);
    check("rel.ovf_sticky", ovf_r, 1'b1);
    model_check("rel_end");
    tick();

    // Asynchronous reset mid-burst, observed before any clock edge
    for (int k = 0; k < 8; k++) cycle("burst", 1'b1, 32'h3000_0000 + k, 1'b0, got, took);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.out_vld", bus.out_vld, 1'b0);
    check("arst.stall", bus.stall_r, 1'b0);
    check("arst.level", level_r, 0);
    check("arst.ovf", ovf_r, 1'b0);
    do_reset();

    // Simultaneous push and pop at level 8
    for (int k = 0; k < 8; k++) cycle("sim_fill", 1'b1, 32'h2000_0000 + k, 1'b0, got, took);
    for (int j = 0; j < 20; j++) begin
      drive(1'b1, 32'h2000_0008 + j, 1'b1);
      check("sim.level", level_r, 8);
      check("sim.stall", bus.stall_r, 1'b1);
      check("sim.data", bus.out, 32'h2000_0000 + j);
      model_check("sim");
      tick();
    end
    for (int k = 0; k < 10; k++) cycle("sim_drain", 1'b0, '0, 1'b1, got, took);

    // Randomized traffic against the model, light then heavy backpressure
    do_reset();
    for (int n = 0; n < 800; n++) begin
      int acc_pct;
      int vld_pct;
      acc_pct = (n < 400) ? 55 : 10;
      vld_pct = bus.stall_r ? 20 : 75;
      cycle("rand", ($urandom_range(0, 99) < vld_pct), $urandom,
            ($urandom_range(0, 99) < acc_pct), got, took);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
